// File: rtl/trisc_pkg.sv
// trisc_pkg: shared state encoding, opcodes and control-word bit indices for the TRISC sequencer
package trisc_pkg;

    localparam int WAIT_MAX_DFLT = 15;

    typedef enum logic [3:0] {
        S_IDLE, S_F1, S_F2, S_F3, S_DEC, S_E1, S_E2, S_E3, S_E4, S_HALT
    } state_e;

    localparam logic [0:3] OP_NOP   = 4'd0;
    localparam logic [0:3] OP_LOAD  = 4'd1;
    localparam logic [0:3] OP_STORE = 4'd2;
    localparam logic [0:3] OP_ADD   = 4'd3;
    localparam logic [0:3] OP_SUB   = 4'd4;
    localparam logic [0:3] OP_JMP   = 4'd5;
    localparam logic [0:3] OP_JZ    = 4'd6;
    localparam logic [0:3] OP_HALT  = 4'd7;

    localparam int CW_PC_INC  = 0;
    localparam int CW_PC_LOAD = 1;
    localparam int CW_MAR_LD  = 2;
    localparam int CW_MEM_RD  = 3;
    localparam int CW_MEM_WR  = 4;
    localparam int CW_IR_LD   = 5;
    localparam int CW_ACC_LD  = 6;
    localparam int CW_ALU_SUB = 7;
    localparam int CW_MDR_LD  = 8;
    localparam int CW_ACC_OE  = 9;
    localparam int CW_B_LD    = 10;
    localparam int CW_PC_OE   = 11;
    localparam int CW_IR_OE   = 12;
    localparam int CW_MDR_OE  = 13;
    localparam int CW_HALT    = 14;

    typedef logic [0:14] cw_t;

endpackage

// File: rtl/trisc_cw_decode.sv
// trisc_cw_decode: pure combinational state + latched opcode -> control word C[0:14]
module trisc_cw_decode
    import trisc_pkg::*;
(
    input  state_e     state_i,
    input  logic [0:3] op_i,
    input  logic       hold_i,
    output cw_t        c_o
);

    always_comb begin
        c_o = '0;
        case (state_i)
            S_F1: begin
                c_o[CW_PC_OE]  = !hold_i;
                c_o[CW_MAR_LD] = !hold_i;
            end
            // Moore word: the datapath qualifies MDR_LD/PC_INC with MemReady during waits
            S_F2: begin
                c_o[CW_MEM_RD] = 1'b1;
                c_o[CW_MDR_LD] = 1'b1;
                c_o[CW_PC_INC] = 1'b1;
            end
            S_F3: begin
                c_o[CW_MDR_OE] = 1'b1;
                c_o[CW_IR_LD]  = 1'b1;
            end
            S_E1: begin
                c_o[CW_IR_OE]   = 1'b1;
                c_o[CW_PC_LOAD] = op_i == OP_JMP || op_i == OP_JZ;
                c_o[CW_MAR_LD]  = !(op_i == OP_JMP || op_i == OP_JZ);
            end
            S_E2: begin
                c_o[CW_ACC_OE] = op_i == OP_STORE;
                c_o[CW_MEM_WR] = op_i == OP_STORE;
                c_o[CW_MEM_RD] = op_i != OP_STORE;
                c_o[CW_MDR_LD] = op_i != OP_STORE;
            end
            S_E3: begin
                c_o[CW_MDR_OE] = 1'b1;
                c_o[CW_ACC_LD] = op_i == OP_LOAD;
                c_o[CW_B_LD]   = op_i != OP_LOAD;
            end
            S_E4: begin
                c_o[CW_ACC_LD]  = 1'b1;
                c_o[CW_ALU_SUB] = op_i == OP_SUB;
            end
            S_HALT: c_o[CW_HALT] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/trisc_seq_ctrl.sv
// trisc_seq_ctrl: multi-cycle fetch/decode/execute sequencer with wait-state timeout and single-step
module trisc_seq_ctrl
    import trisc_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic        step_mode_i,
    input  logic        step_i,
    input  logic [0:3]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic [0:14] c_o,
    output logic [0:3]  state_o,
    output logic        instr_done_o,
    output logic        halted_o,
    output logic        illegal_op_o,
    output logic        bus_err_o
);

    localparam int WW = $clog2(WAIT_MAX + 1);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [0:3]    op_q, op_d;
    logic          hold_q, hold_d, step_q, bus_err_q, bus_err_d;
    logic          step_edge, mem_st;

    assign step_edge = step_i && !step_q;
    assign mem_st    = state_q == S_F2 || state_q == S_E2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            op_q      <= '0;
            hold_q    <= 1'b0;
            step_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            hold_q    <= hold_d;
            step_q    <= step_i;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hold_d    = hold_q;
        bus_err_d = bus_err_q;
        wait_d    = '0;
        case (state_q)
            S_IDLE: state_d = run_i ? S_F1 : S_IDLE;
            S_F1: begin
                if (!hold_q) state_d = S_F2;
                else if (step_edge) hold_d = 1'b0;
            end
            S_F2: state_d = mem_ready_i ? S_F3 : S_F2;
            S_F3: state_d = S_DEC;
            S_DEC: begin
                op_d = opcode_i;
                case (opcode_i)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_JMP: state_d = S_E1;
                    OP_JZ:   state_d = zero_i ? S_E1 : S_F1;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_F1;
                endcase
            end
            S_E1: state_d = (op_q == OP_JMP || op_q == OP_JZ) ? S_F1 : S_E2;
            S_E2: if (mem_ready_i) state_d = (op_q == OP_STORE) ? S_F1 : S_E3;
            S_E3: state_d = (op_q == OP_LOAD) ? S_F1 : S_E4;
            S_E4: state_d = S_F1;
            default: state_d = S_HALT;
        endcase
        if (mem_st && !mem_ready_i) begin
            wait_d = wait_q + 1'b1;
            if (wait_q == WW'(WAIT_MAX - 1)) begin
                state_d   = S_HALT;
                bus_err_d = 1'b1;
                wait_d    = '0;
            end
        end
        // Step mode is latched on every entry into the instruction boundary
        if (state_d == S_F1 && state_q != S_F1) hold_d = step_mode_i;
    end

    trisc_cw_decode u_cw_decode (
        .state_i (state_q),
        .op_i    (op_q),
        .hold_i  (hold_q),
        .c_o     (c_o)
    );

    assign state_o      = state_q;
    assign instr_done_o = state_q inside {S_DEC, S_E1, S_E2, S_E3, S_E4} && state_d == S_F1;
    assign illegal_op_o = state_q == S_DEC && opcode_i >= 4'd8;
    assign halted_o     = state_q == S_HALT;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_trisc_seq_ctrl.sv
// tb_trisc_seq_ctrl: random instruction programs expanded into expected per-cycle traces and compared
module tb_trisc_seq_ctrl;

    localparam int PC_INC = 0, PC_LOAD = 1, MAR_LD = 2, MEM_RD = 3, MEM_WR = 4, IR_LD = 5;
    localparam int ACC_LD = 6, ALU_SUB = 7, MDR_LD = 8, ACC_OE = 9, B_LD = 10, PC_OE = 11;
    localparam int IR_OE = 12, MDR_OE = 13, HALT = 14;
    localparam logic [3:0] IDLE = 0, F1 = 1, F2 = 2, F3 = 3, DEC = 4;
    localparam logic [3:0] E1 = 5, E2 = 6, E3 = 7, E4 = 8, HLT = 9;

    typedef struct {
        logic [3:0]  st;
        logic [0:14] c;
        bit          done, ill, hlt, berr, rdy, run, sm, stp, z;
        logic [3:0]  op;
    } rec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        run_i = 1'b0, step_mode_i = 1'b0, step_i = 1'b0, zero_i = 1'b0, mem_ready_i = 1'b0;
    logic [0:3]  opcode_i = '0;
    logic [0:14] c_o;
    logic [0:3]  state_o;
    logic        instr_done_o, halted_o, illegal_op_o, bus_err_o;

    rec_t q[$];
    bit   berr_m;
    int   checks, errors;

    always #5 clk = ~clk;

    trisc_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run_i),
        .step_mode_i  (step_mode_i),
        .step_i       (step_i),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .c_o          (c_o),
        .state_o      (state_o),
        .instr_done_o (instr_done_o),
        .halted_o     (halted_o),
        .illegal_op_o (illegal_op_o),
        .bus_err_o    (bus_err_o)
    );

    function automatic logic [0:14] cb(int i);
        logic [0:14] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t mk(logic [3:0] st, logic [0:14] c);
        rec_t r;
        r.st = st; r.c = c; r.done = 0; r.ill = 0; r.hlt = (st == HLT); r.berr = berr_m;
        r.rdy = 1'($urandom); r.run = 1'($urandom); r.sm = 1'($urandom);
        r.stp = 1'($urandom); r.z = 1'($urandom); r.op = 4'($urandom);
        return r;
    endfunction

    function automatic void halt_cycles();
        for (int i = 0; i < 3; i++) q.push_back(mk(HLT, cb(HALT)));
    endfunction

    // memory phase: w not-ready cycles then a ready one; 15 or more waits is a bus error
    function automatic bit mem(logic [3:0] st, logic [0:14] c, int w, bit done);
        rec_t r;
        for (int i = 0; i < w && i < 15; i++) begin
            r = mk(st, c); r.rdy = 0; q.push_back(r);
        end
        if (w >= 15) begin
            berr_m = 1;
            halt_cycles();
            return 1;
        end
        r = mk(st, c); r.rdy = 1; r.done = done; q.push_back(r);
        return 0;
    endfunction

    function automatic void start_prog();
        rec_t r;
        int n = $urandom_range(1, 2);
        for (int i = 0; i < n; i++) begin
            r = mk(IDLE, '0); r.run = 0; q.push_back(r);
        end
        r = mk(IDLE, '0); r.run = 1; q.push_back(r);
    endfunction

    function automatic bit add_instr(int op, bit z, bit sm, int w1, int w2);
        rec_t r;
        int last = q.size() - 1;
        int n = $urandom_range(1, 3);
        q[last].sm = sm;
        if (sm) begin
            for (int i = 0; i < n; i++) begin
                r = mk(F1, '0); r.stp = 0; q.push_back(r);
            end
            r = mk(F1, '0); r.stp = 1; q.push_back(r);
        end
        q.push_back(mk(F1, cb(PC_OE) | cb(MAR_LD)));
        if (mem(F2, cb(MEM_RD) | cb(MDR_LD) | cb(PC_INC), w1, 0)) return 1;
        q.push_back(mk(F3, cb(MDR_OE) | cb(IR_LD)));
        r = mk(DEC, '0); r.op = 4'(op); r.z = z; r.ill = op >= 8;
        r.done = op == 0 || op >= 8 || (op == 6 && !z);
        q.push_back(r);
        if (op == 7) begin
            halt_cycles();
            return 1;
        end
        if (op == 5 || (op == 6 && z)) begin
            r = mk(E1, cb(IR_OE) | cb(PC_LOAD)); r.done = 1; q.push_back(r);
        end else if (op >= 1 && op <= 4) begin
            q.push_back(mk(E1, cb(IR_OE) | cb(MAR_LD)));
            if (op == 2) return mem(E2, cb(ACC_OE) | cb(MEM_WR), w2, 1);
            if (mem(E2, cb(MEM_RD) | cb(MDR_LD), w2, 0)) return 1;
            if (op == 1) begin
                r = mk(E3, cb(MDR_OE) | cb(ACC_LD)); r.done = 1; q.push_back(r);
            end else begin
                q.push_back(mk(E3, cb(MDR_OE) | cb(B_LD)));
                r = mk(E4, cb(ACC_LD)); r.done = 1;
                if (op == 4) r.c |= cb(ALU_SUB);
                q.push_back(r);
            end
        end
        return 0;
    endfunction

    task automatic cyc(rec_t r);
        run_i = r.run; step_mode_i = r.sm; step_i = r.stp;
        opcode_i = r.op; zero_i = r.z; mem_ready_i = r.rdy;
        @(negedge clk);
        check("state", state_o, r.st);
        check("c", c_o, r.c);
        check("instr_done", instr_done_o, r.done);
        check("illegal_op", illegal_op_o, r.ill);
        check("halted", halted_o, r.hlt);
        check("bus_err", bus_err_o, r.berr);
        @(posedge clk);
        #1;
    endtask

    task automatic run_queue(int e2_stop);
        int n = 0;
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            cyc(r);
            if (r.st == E2) n++;
            if (e2_stop > 0 && n >= e2_stop) q.delete();
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        run_i = 1'b0;
        #1;
        check("rst_state", state_o, IDLE);
        check("rst_c", c_o, 0);
        check("rst_bus_err", bus_err_o, 0);
        check("rst_halted", halted_o, 0);
        check("rst_done", instr_done_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        berr_m = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        do_reset();
        start_prog();
        void'(add_instr(1, 0, 0, 0, 10));
        run_queue(3);
        do_reset();
        start_prog();
        void'(add_instr(1, 0, 0, 0, 0));
        void'(add_instr(4, 0, 0, 3, 3));
        void'(add_instr(6, 1, 0, 0, 0));
        void'(add_instr(6, 0, 0, 0, 0));
        void'(add_instr(2, 0, 0, 1, 2));
        void'(add_instr(3, 1, 0, 0, 14));
        void'(add_instr(5, 0, 0, 0, 0));
        void'(add_instr(0, 0, 1, 0, 0));
        void'(add_instr(0, 1, 1, 2, 0));
        void'(add_instr(9, 0, 1, 0, 0));
        void'(add_instr(0, 0, 0, 20, 0));
        run_queue(0);
        do_reset();
        for (int p = 0; p < 40; p++) begin
            bit h;
            h = 0;
            start_prog();
            for (int i = 0; i < 12 && !h; i++)
                h = add_instr($urandom_range(0, 15), 1'($urandom), $urandom_range(0, 3) == 0,
                              ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 3),
                              ($urandom_range(0, 19) == 0) ? 16 : $urandom_range(0, 3));
            if (!h) void'(add_instr(7, 0, 0, 0, 0));
            run_queue(0);
            do_reset();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
